// File: rtl/mips_alu_unit_if.sv
// Operand/result bundle between the datapath and the ALU unit.
// No valid/ready: operands are sampled every cycle, and HI/LO update on clk_enable.
interface mips_alu_unit_if;
  logic        clk_enable;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        unsign;
  logic [31:0] result;
  logic        eq;
  logic        lt;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output clk_enable, a, b, imm, alusrc, aluop, opcode, func, unsign,
    input  result, eq, lt, hi, lo
  );

  modport slave (
    input  clk_enable, a, b, imm, alusrc, aluop, opcode, func, unsign,
    output result, eq, lt, hi, lo
  );
endinterface

// File: rtl/mips_alu_unit.sv
// MIPS ALU: ALU-control decode, combinational result and compare flags,
// and HI/LO registers written by the MULT, DIV, MTHI and MTLO operations.
module mips_alu_unit #(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  mips_alu_unit_if.slave   bus
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_MULT = 4'b1100,
    ALU_DIV  = 4'b1101,
    ALU_MTHI = 4'b1110,
    ALU_MTLO = 4'b1111
  } alu_ctrl_t;

  alu_ctrl_t   alu_ctrl;
  logic [31:0] branch_data;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        div_ovf;

  // REGIMM and BLEZ/BGTZ compare rs against zero rather than the immediate.
  assign branch_data = (bus.opcode == 6'b000001 || bus.opcode == 6'b000110 ||
                        bus.opcode == 6'b000111) ? 32'h0 : bus.imm;
  assign op_b  = bus.alusrc ? branch_data : bus.b;
  assign shamt = bus.a[4:0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (bus.aluop)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (bus.func)
          6'b100000, 6'b100001: alu_ctrl = ALU_ADD;
          6'b100010, 6'b100011: alu_ctrl = ALU_SUB;
          6'b100100:            alu_ctrl = ALU_AND;
          6'b100101:            alu_ctrl = ALU_OR;
          6'b100110:            alu_ctrl = ALU_XOR;
          6'b100111:            alu_ctrl = ALU_NOR;
          6'b101010, 6'b101011: alu_ctrl = ALU_SLT;
          6'b000000, 6'b000100: alu_ctrl = ALU_SLL;
          6'b000010, 6'b000110: alu_ctrl = ALU_SRL;
          6'b000011, 6'b000111: alu_ctrl = ALU_SRA;
          6'b011000, 6'b011001: alu_ctrl = ALU_MULT;
          6'b011010, 6'b011011: alu_ctrl = ALU_DIV;
          6'b010001:            alu_ctrl = ALU_MTHI;
          6'b010011:            alu_ctrl = ALU_MTLO;
          default:              alu_ctrl = ALU_ADD;
        endcase
      end
      default: begin
        case (bus.opcode)
          6'b001000, 6'b001001: alu_ctrl = ALU_ADD;
          6'b001010, 6'b001011: alu_ctrl = ALU_SLT;
          6'b001100:            alu_ctrl = ALU_AND;
          6'b001101:            alu_ctrl = ALU_OR;
          6'b001110:            alu_ctrl = ALU_XOR;
          6'b001111:            alu_ctrl = ALU_LUI;
          default:              alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign bus.eq = (bus.a == op_b);
  assign bus.lt = bus.unsign ? (bus.a < op_b) : ($signed(bus.a) < $signed(op_b));

  always_comb begin
    bus.result = 32'h0;
    case (alu_ctrl)
      ALU_AND: bus.result = bus.a & op_b;
      ALU_OR:  bus.result = bus.a | op_b;
      ALU_ADD: bus.result = bus.a + op_b;
      ALU_XOR: bus.result = bus.a ^ op_b;
      ALU_NOR: bus.result = ~(bus.a | op_b);
      ALU_SUB: bus.result = bus.a - op_b;
      ALU_SLT: bus.result = {31'h0, bus.lt};
      ALU_SLL: bus.result = op_b << shamt;
      ALU_SRL: bus.result = op_b >> shamt;
      ALU_SRA: bus.result = $signed(op_b) >>> shamt;
      ALU_LUI: bus.result = op_b << 16;
      default: bus.result = 32'h0;
    endcase
  end

  // Operands are widened explicitly so one unsigned 64-bit multiply serves both modes.
  assign prod = bus.unsign ? ({32'h0, bus.a} * {32'h0, op_b})
                           : ({{32{bus.a[31]}}, bus.a} * {{32{op_b[31]}}, op_b});

  assign div_ovf = !bus.unsign && bus.a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;

  always_comb begin
    quot = 32'h0;
    rem  = 32'h0;
    if (bus.unsign) begin
      quot = bus.a / op_b;
      rem  = bus.a % op_b;
    end else if (div_ovf) begin
      quot = 32'h8000_0000;
      rem  = 32'h0;
    end else begin
      quot = $unsigned($signed(bus.a) / $signed(op_b));
      rem  = $unsigned($signed(bus.a) % $signed(op_b));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else if (bus.clk_enable) begin
      case (alu_ctrl)
        ALU_MULT: begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end
        ALU_DIV: begin
          // A zero divisor leaves HI/LO untouched.
          if (op_b != 32'h0) begin
            hi_q <= rem;
            lo_q <= quot;
          end
        end
        ALU_MTHI: hi_q <= bus.a;
        ALU_MTLO: lo_q <= bus.a;
        default: ;
      endcase
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_mips_alu_unit.sv
// Directed-vector bench for mips_alu_unit: combinational ALU ops, compare
// flags, branch-data operand, HI/LO writes, divide corner cases and reset.
module tb_mips_alu_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  mips_alu_unit_if bus();

  mips_alu_unit #(.HILO_RST(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [1:0] aluop, input logic [5:0] opcode,
                       input logic [5:0] func, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic alusrc, input logic unsign);
    bus.aluop  = aluop;
    bus.opcode = opcode;
    bus.func   = func;
    bus.a      = a;
    bus.b      = b;
    bus.imm    = imm;
    bus.alusrc = alusrc;
    bus.unsign = unsign;
    #1;
  endtask

  // R-type shortcut: aluop=10, opcode 0, operand B from b.
  task automatic drive_r(input logic [5:0] func, input logic [31:0] a,
                         input logic [31:0] b, input logic unsign);
    drive(2'b10, 6'b000000, func, a, b, 32'h0, 1'b0, unsign);
  endtask

  // One enabled edge, then back to a quiet point mid-cycle.
  task automatic enabled_edge(input logic en);
    bus.clk_enable = en;
    @(posedge clk);
    #1;
    bus.clk_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    bus.clk_enable = 1'b0;
    drive(2'b00, 6'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // ---- combinational ALU ----
    drive_r(6'b100001, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("addu_wrap", bus.result, 32'h8000_0000);
    drive_r(6'b101010, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check("slt_s_res", bus.result, 32'h1);
    check("slt_s_lt", {31'h0, bus.lt}, 32'h1);
    drive_r(6'b101010, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check("slt_u_res", bus.result, 32'h0);
    check("slt_u_lt", {31'h0, bus.lt}, 32'h0);
    drive_r(6'b000011, 32'h4, 32'h8000_0000, 1'b0);
    check("sra", bus.result, 32'hF800_0000);
    drive_r(6'b000000, 32'h4, 32'h8000_0000, 1'b0);
    check("sll", bus.result, 32'h0);
    drive_r(6'b000010, 32'h4, 32'h8000_0000, 1'b0);
    check("srl", bus.result, 32'h0800_0000);
    drive_r(6'b100111, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
    check("nor", bus.result, 32'hF0F0_FF0F);
    drive_r(6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    check("xor", bus.result, 32'hF0F0_F0F0);
    drive_r(6'b100011, 32'h3, 32'h5, 1'b0);
    check("subu", bus.result, 32'hFFFF_FFFE);
    drive_r(6'b111111, 32'h10, 32'h22, 1'b0);
    check("func_dflt_add", bus.result, 32'h32);
    drive(2'b00, 6'b100011, 6'b0, 32'h3, 32'h4, 32'h0, 1'b0, 1'b0);
    check("aluop_add", bus.result, 32'h7);
    drive(2'b01, 6'b000100, 6'b0, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0);
    check("aluop_sub", bus.result, 32'hFFFF_FFFE);
    drive(2'b11, 6'b001111, 6'b0, 32'h0, 32'h0, 32'h1234, 1'b1, 1'b0);
    check("lui", bus.result, 32'h1234_0000);
    drive(2'b11, 6'b001100, 6'b0, 32'h1234, 32'h0, 32'h00FF, 1'b1, 1'b0);
    check("andi", bus.result, 32'h0000_0034);
    drive(2'b11, 6'b001101, 6'b0, 32'h1200, 32'h0, 32'h0034, 1'b1, 1'b0);
    check("ori", bus.result, 32'h0000_1234);
    drive(2'b11, 6'b001011, 6'b0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("sltiu", bus.result, 32'h1);

    // ---- branch-data operand ----
    drive(2'b01, 6'b000111, 6'b0, 32'h5, 32'h77, 32'h1234, 1'b1, 1'b0);
    check("bd_zero_res", bus.result, 32'h5);
    check("bd_zero_eq", {31'h0, bus.eq}, 32'h0);
    check("bd_zero_lt", {31'h0, bus.lt}, 32'h0);
    drive(2'b01, 6'b000100, 6'b0, 32'h9, 32'h9, 32'h1234, 1'b0, 1'b0);
    check("beq_eq", {31'h0, bus.eq}, 32'h1);
    drive(2'b01, 6'b000100, 6'b0, 32'h5, 32'h9, 32'h1234, 1'b1, 1'b0);
    check("bd_imm_res", bus.result, 32'hFFFF_EDD1);
    check("bd_imm_lt", {31'h0, bus.lt}, 32'h1);

    // ---- HI/LO ----
    drive_r(6'b011000, 32'hFFFF_FFFE, 32'h3, 1'b0);
    check("mult_res0", bus.result, 32'h0);
    enabled_edge(1'b1);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    drive_r(6'b011010, 32'hFFFF_FFF9, 32'h2, 1'b0);
    enabled_edge(1'b1);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    drive_r(6'b011010, 32'h1234, 32'h0, 1'b0);
    enabled_edge(1'b1);
    check("div0_lo", bus.lo, 32'hFFFF_FFFD);
    check("div0_hi", bus.hi, 32'hFFFF_FFFF);

    drive_r(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    enabled_edge(1'b1);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'h0);

    drive_r(6'b011001, 32'hFFFF_FFFF, 32'h2, 1'b1);
    enabled_edge(1'b1);
    check("multu_hi", bus.hi, 32'h1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    drive_r(6'b011011, 32'd100, 32'd7, 1'b1);
    enabled_edge(1'b1);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    drive_r(6'b010001, 32'h1111_2222, 32'h0, 1'b0);
    enabled_edge(1'b0);
    check("noen_hi", bus.hi, 32'd2);

    drive_r(6'b010011, 32'h0000_CAFE, 32'h0, 1'b0);
    enabled_edge(1'b1);
    check("mtlo_lo", bus.lo, 32'h0000_CAFE);
    check("mtlo_hi", bus.hi, 32'd2);

    drive_r(6'b010001, 32'hDEAD_BEEF, 32'h0, 1'b0);
    enabled_edge(1'b1);
    check("mthi_hi", bus.hi, 32'hDEAD_BEEF);

    // ---- asynchronous reset between edges ----
    #2;
    reset = 1'b0;
    #1;
    check("arst_hi", bus.hi, 32'h0);
    check("arst_lo", bus.lo, 32'h0);
    drive_r(6'b100001, 32'h5, 32'h6, 1'b0);
    check("arst_comb", bus.result, 32'hB);
    drive_r(6'b010001, 32'hDEAD_BEEF, 32'h0, 1'b0);
    enabled_edge(1'b1);
    check("arst_hold_hi", bus.hi, 32'h0);
    reset = 1'b1;
    enabled_edge(1'b0);
    check("rel_noen_hi", bus.hi, 32'h0);
    enabled_edge(1'b1);
    check("rel_en_hi", bus.hi, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
